dma_stream_controller: RTL
==========================

# dma_stream_controller

Parametrised single-channel DMA engine that moves whole words between BRAM port B and the UART byte FIFOs. It replaces the fixed 32-bit word controller: word width, address width, count width and BRAM read latency are parameters, and the block adds FIFO backpressure, abort on grant loss, error reporting and a progress counter. It sits between the core's DMA command outputs (address, count, mode, grant) and the BRAM port-B / UART TX-RX FIFO pair.

## Interface
- DATA_W, 32, BRAM word width; multiple of 8; BPW = DATA_W/8 bytes per word
- ADDR_W, 32, BRAM byte-address width
- COUNT_W, 16, word-count width
- RD_LAT, 1, BRAM read latency in cycles (1 or 2)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request, sampled in IDLE only
- i_grant  in  1  bus grant; must stay high for the whole transfer
- i_mode  in  2  01 = BRAM→UART (TX), 10 = UART→BRAM (RX), 00/11 invalid
- i_base_addr  in  ADDR_W  first byte address, word aligned
- i_count  in  COUNT_W  number of words to move
- o_busy  out  1  high from the accepted start until DONE/abort
- o_done  out  1  one-cycle pulse on normal completion
- o_abort  out  1  one-cycle pulse when grant is lost mid-transfer
- o_err  out  1  one-cycle pulse on start with an invalid mode
- o_words_done  out  COUNT_W  words completed in the current/last transfer
- o_addrb  out  ADDR_W  BRAM port-B byte address
- o_web  out  BPW  BRAM port-B byte write enables
- o_dinb  out  DATA_W  BRAM port-B write data
- i_doutb  in  DATA_W  BRAM port-B read data
- o_tx_dv  out  1  push o_tx_byte into the TX FIFO
- o_tx_byte  out  8  TX byte
- i_tx_full  in  1  TX FIFO full
- o_rx_rd  out  1  pop one byte from the RX FIFO
- i_rx_byte  in  8  RX FIFO data, valid the cycle after o_rx_rd
- i_rx_empty  in  1  RX FIFO empty

## Operation
- States: IDLE, RD_REQ, RD_WAIT, TX_BYTE, RX_REQ, RX_WAIT, WR_WORD, DONE.
- IDLE: on i_start & i_grant:
  - latch base address into addr and i_count into remaining; clear o_words_done.
  - mode 01 → RD_REQ; mode 10 → RX_REQ.
  - invalid mode → o_err pulse, stay IDLE.
  - count 0 → DONE directly with no bus/FIFO activity.
- i_start with i_grant low is ignored. i_start while busy is ignored.
- RD_REQ: o_addrb = addr, o_web = 0 for one cycle → RD_WAIT.
- RD_WAIT: wait RD_LAT cycles, capture i_doutb into the shift register and clear the byte index → TX_BYTE.
- TX_BYTE: each cycle with !i_tx_full, pulse o_tx_dv with byte[idx].
  - Little-endian: byte 0 = bits [7:0] goes first.
  - When i_tx_full is high, no push occurs and the state holds.
  - After byte BPW-1, the word is complete (see word completion); next state is DONE if remaining reaches 0, else RD_REQ.
- RX_REQ: when !i_rx_empty, pulse o_rx_rd → RX_WAIT; otherwise hold.
- RX_WAIT: store i_rx_byte into lane idx.
  - idx < BPW-1 → RX_REQ.
  - otherwise → WR_WORD.
- WR_WORD: one cycle with o_addrb = addr, o_dinb = assembled word, o_web = all ones. Word completion applies; then DONE or RX_REQ.
- Word completion: addr += BPW (wraps modulo 2^ADDR_W), remaining −1, o_words_done +1.
- DONE: o_done pulse for one cycle, o_busy low in the same cycle → IDLE.
- Grant loss: i_grant low in any non-IDLE, non-DONE state → o_abort pulse, → IDLE.
  - o_web and o_tx_dv are forced 0 that cycle.
  - A partially received word is discarded. o_words_done holds the completed count.

## Timing
- Reset (async, rst_n low): state IDLE; all outputs 0, including o_addrb, o_dinb, o_web, o_words_done and all pulses.
- Reset mid-transfer aborts immediately with no o_done/o_abort pulse.
- All outputs are registered; o_busy rises the cycle after start acceptance.
- TX word without backpressure: 1 + RD_LAT + BPW cycles. First o_tx_dv is RD_LAT+2 cycles after start acceptance.
- RX word with a non-empty FIFO: 2·BPW + 1 cycles.
- o_done is asserted one cycle after the final o_tx_dv or WR_WORD cycle.
- o_tx_dv and o_rx_rd are never high in the same cycle; o_web is nonzero only in WR_WORD.

## Test plan
- TX, base 0x100, count 2, BRAM[0x100]=0x44332211, [0x104]=0x88776655 → bytes 11 22 33 44 55 66 77 88 in order; o_words_done=2; one o_done pulse.
- TX with i_tx_full high for 5 cycles after the 2nd byte → no push while full; byte order unchanged; done latency +5 cycles.
- RX, base 0x40, count 1, FIFO bytes AA BB CC DD → single write 0xDDCCBBAA at 0x40 with o_web=4'hF; o_done pulse.
- count=0, mode 01 → o_done the cycle after acceptance; no o_tx_dv, o_addrb stays 0; mode 11 → o_err pulse, o_busy stays 0.
- RX count 3, i_grant dropped after 1 word + 2 bytes → o_abort pulse, o_words_done=1, no further o_web/o_rx_rd.
- TX count 4 (variant: RD_LAT=2, DATA_W=64), rst_n low mid-transfer → all outputs 0 asynchronously; a fresh start after reset runs correctly from the new base.

Source files
------------

// File: rtl/dma_stream_controller.sv
// Single-channel DMA engine moving whole words between BRAM port B and the UART byte FIFOs.
// Handles FIFO backpressure, abort on grant loss, invalid-mode errors and a progress counter.
module dma_stream_controller #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_grant,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [COUNT_W-1:0]    i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_abort,
  output logic                  o_err,
  output logic [COUNT_W-1:0]    o_words_done,
  output logic [ADDR_W-1:0]     o_addrb,
  output logic [DATA_W/8-1:0]   o_web,
  output logic [DATA_W-1:0]     o_dinb,
  input  logic [DATA_W-1:0]     i_doutb,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_full,
  output logic                  o_rx_rd,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_empty
);

  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BPW - 1);
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BPW);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StTxByte,
    StRxReq,
    StRxWait,
    StWrWord,
    StDone
  } state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [COUNT_W-1:0]   remaining_q;
  logic [DATA_W-1:0]    shreg_q;
  logic [IDX_W-1:0]     idx_q;
  logic [1:0]           lat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      remaining_q  <= '0;
      shreg_q      <= '0;
      idx_q        <= '0;
      lat_q        <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_abort      <= 1'b0;
      o_err        <= 1'b0;
      o_words_done <= '0;
      o_addrb      <= '0;
      o_web        <= '0;
      o_dinb       <= '0;
      o_tx_dv      <= 1'b0;
      o_tx_byte    <= '0;
      o_rx_rd      <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      o_err   <= 1'b0;
      o_tx_dv <= 1'b0;
      o_rx_rd <= 1'b0;
      o_web   <= '0;

      if (state_q != StIdle && state_q != StDone && !i_grant) begin
        // Grant lost: drop the transfer, keep the completed-word count
        o_abort <= 1'b1;
        o_busy  <= 1'b0;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_start && i_grant) begin
              if (i_mode == 2'b01 || i_mode == 2'b10) begin
                addr_q       <= i_base_addr;
                remaining_q  <= i_count;
                o_words_done <= '0;
                idx_q        <= '0;
                o_busy       <= 1'b1;
                if (i_count == '0) begin
                  state_q <= StDone;
                end else if (i_mode == 2'b01) begin
                  o_addrb <= i_base_addr;
                  state_q <= StRdReq;
                end else begin
                  state_q <= StRxReq;
                end
              end else begin
                o_err <= 1'b1;
              end
            end
          end

          StRdReq: begin
            lat_q   <= '0;
            state_q <= StRdWait;
          end

          StRdWait: begin
            if (lat_q == LAT_LAST) begin
              shreg_q <= i_doutb;
              idx_q   <= '0;
              state_q <= StTxByte;
            end else begin
              lat_q <= lat_q + 2'd1;
            end
          end

          StTxByte: begin
            if (!i_tx_full) begin
              // Little-endian: lowest lane leaves first, word shifts down
              o_tx_dv   <= 1'b1;
              o_tx_byte <= shreg_q[7:0];
              shreg_q   <= shreg_q >> 8;
              idx_q     <= idx_q + 1'b1;
              if (idx_q == IDX_LAST) begin
                addr_q       <= addr_q + ADDR_STEP;
                remaining_q  <= remaining_q - 1'b1;
                o_words_done <= o_words_done + 1'b1;
                if (remaining_q == COUNT_W'(1)) begin
                  state_q <= StDone;
                end else begin
                  o_addrb <= addr_q + ADDR_STEP;
                  state_q <= StRdReq;
                end
              end
            end
          end

          StRxReq: begin
            if (!i_rx_empty) begin
              o_rx_rd <= 1'b1;
              state_q <= StRxWait;
            end
          end

          StRxWait: begin
            // Bytes enter at the top lane; after BPW bytes byte 0 sits in [7:0]
            shreg_q <= (shreg_q >> 8) | (DATA_W'(i_rx_byte) << (DATA_W - 8));
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= StWrWord;
            end else begin
              state_q <= StRxReq;
            end
          end

          StWrWord: begin
            o_addrb      <= addr_q;
            o_dinb       <= shreg_q;
            o_web        <= '1;
            idx_q        <= '0;
            addr_q       <= addr_q + ADDR_STEP;
            remaining_q  <= remaining_q - 1'b1;
            o_words_done <= o_words_done + 1'b1;
            if (remaining_q == COUNT_W'(1)) begin
              state_q <= StDone;
            end else begin
              state_q <= StRxReq;
            end
          end

          StDone: begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            state_q <= StIdle;
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
